// File: rtl/enc_8_serial.sv
// Serial priority encoder: captures a request vector, emits set-bit indices low to high.
// Optional `last` output when ENC_8_SERIAL_LAST_EN is defined.
module enc_8_serial #(
  parameter int widtho = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2**widtho-1:0] in,
  input  logic              ready,
  output logic [widtho-1:0] idx,
  output logic              valid,
`ifdef ENC_8_SERIAL_LAST_EN
  output logic              last,
`endif
  output logic              busy
);

  localparam int widthi = 2**widtho;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic              r_state;
  logic [widthi-1:0] r_pending;
  logic [widtho-1:0] r_idx;
  logic              r_valid;
  logic              r_last;

  logic [widthi-1:0] w_rem;
  logic              w_cap;
  logic              w_take;

  function automatic logic [widtho-1:0] f_lsb(
    input logic [widthi-1:0] v
  );
    logic [widtho-1:0] r;
    r = '0;
    for (int i = widthi-1; i >= 0; i--)
      if (v[i]) r = i[widtho-1:0];
    return r;
  endfunction

  function automatic logic f_one(
    input logic [widthi-1:0] v
  );
    return (v & (v - 1'b1)) == '0;
  endfunction

  always_comb begin
    w_rem = r_pending;
    w_rem[r_idx] = 1'b0;
  end

  assign w_cap  = (r_state == IDLE) && !enable && (in != '0);
  assign w_take = (r_state == BUSY) && r_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_cap) begin
      r_state   <= BUSY;
      r_pending <= in;
      r_idx     <= f_lsb(in);
      r_valid   <= 1'b1;
      r_last    <= f_one(in);
    end else if (w_take) begin
      r_pending <= w_rem;
      if (w_rem != '0) begin
        r_idx  <= f_lsb(w_rem);
        r_last <= f_one(w_rem);
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_state <= IDLE;
      end
    end
  end

  assign idx   = r_idx;
  assign valid = r_valid;
  assign busy  = (r_state == BUSY);

`ifdef ENC_8_SERIAL_LAST_EN
  assign last = r_last;
`else
  logic w_unused;
  assign w_unused = r_last;
`endif

endmodule

// File: tb/tb_enc_8_serial.sv
// Directed bench for enc_8_serial.
// Checks `last` too when ENC_8_SERIAL_LAST_EN is defined.
module tb_enc_8_serial;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] in;
  logic       ready;
  logic [2:0] idx;
  logic       valid;
  logic       busy;
`ifdef ENC_8_SERIAL_LAST_EN
  logic       last;
`endif

  int n_chk;
  int n_pass;

  enc_8_serial #(.widtho(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .in     (in),
    .ready  (ready),
    .idx    (idx),
    .valid  (valid),
`ifdef ENC_8_SERIAL_LAST_EN
    .last   (last),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [2:0] i, input logic b);
    chk({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, ".idx"},   {29'b0, idx},   {29'b0, i});
    chk({tag, ".busy"},  {31'b0, busy},  {31'b0, b});
  endtask

  task automatic chk_last(input string tag, input logic l);
`ifdef ENC_8_SERIAL_LAST_EN
    chk({tag, ".last"}, {31'b0, last}, {31'b0, l});
`else
    if (l === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    enable = 1'b1;
    in = 8'h00;
    ready = 1'b0;
    #12;
    chk_out("reset", 1'b0, 3'd0, 1'b0);
    chk_last("reset", 1'b0);
    tick();
    rst = 1'b1;

    // 0010_0100 with ready high
    enable = 1'b0; in = 8'b0010_0100; ready = 1'b1;
    tick();
    chk_out("v24.a", 1'b1, 3'd2, 1'b1);
    chk_last("v24.a", 1'b0);
    enable = 1'b1; in = 8'h00;
    tick();
    chk_out("v24.b", 1'b1, 3'd5, 1'b1);
    chk_last("v24.b", 1'b1);
    tick();
    chk_out("v24.c", 1'b0, 3'd5, 1'b0);

    // 1000_0001 stalled, with junk driven during BUSY
    enable = 1'b0; in = 8'h81; ready = 1'b0;
    tick();
    chk_out("v81.cap", 1'b1, 3'd0, 1'b1);
    in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("v81.stall", 1'b1, 3'd0, 1'b1);
    end
    ready = 1'b1;
    tick();
    chk_out("v81.b", 1'b1, 3'd7, 1'b1);
    chk_last("v81.b", 1'b1);
    enable = 1'b1; in = 8'h00;
    tick();
    chk_out("v81.c", 1'b0, 3'd7, 1'b0);

    // full vector then immediate recapture
    enable = 1'b0; in = 8'hFF; ready = 1'b1;
    tick();
    enable = 1'b1; in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_out("vff", 1'b1, 3'(i), 1'b1);
      chk_last("vff", i == 7);
      if (i == 7) begin
        enable = 1'b0; in = 8'h10;
      end
      tick();
    end
    chk_out("vff.idle", 1'b0, 3'd7, 1'b0);
    tick();
    chk_out("v10.a", 1'b1, 3'd4, 1'b1);
    chk_last("v10.a", 1'b1);
    enable = 1'b1; in = 8'h00;
    tick();
    chk_out("v10.b", 1'b0, 3'd4, 1'b0);

    // no capture cases
    enable = 1'b0; in = 8'h00;
    tick();
    chk_out("zero", 1'b0, 3'd4, 1'b0);
    enable = 1'b1; in = 8'h3C;
    tick();
    chk_out("dis", 1'b0, 3'd4, 1'b0);
    tick();
    chk_out("dis2", 1'b0, 3'd4, 1'b0);

    // async reset mid-stream
    enable = 1'b0; in = 8'h0E; ready = 1'b1;
    tick();
    chk_out("v0e.a", 1'b1, 3'd1, 1'b1);
    enable = 1'b1; in = 8'h00;
    #2;
    rst = 1'b0;
    #1;
    chk_out("arst", 1'b0, 3'd0, 1'b0);
    chk_last("arst", 1'b0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post", 1'b0, 3'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/enc_8_serial.md
ENC_8_SERIAL -- requirements
Module: enc_8_serial

Interface
REQ-001 Parameter widtho, default 3: index output width; input vector width widthi = 2**widtho (localparam, 8 by default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  capture enable, active-low (0 = capture allowed).
REQ-005 in  input  widthi  request vector; each set bit is one index to emit.
REQ-006 ready  input  1  consumer accepts current index when high with valid high.
REQ-007 idx  output  widtho  index of the lowest-numbered pending bit, registered.
REQ-008 valid  output  1  idx holds a pending index, registered.
REQ-009 busy  output  1  high while a captured vector still has pending bits (state BUSY).

Function
REQ-010 Two states only: IDLE, BUSY; busy = (state == BUSY).
REQ-011 IDLE: if enable==0 and in!=0 on a rising edge, pending <= in, idx <= index of lowest set bit of in, valid <= 1, state <= BUSY.
REQ-012 IDLE with enable==1 or in==0: no capture; state, pending, idx, valid unchanged (valid stays 0).
REQ-013 Latency: valid and idx appear the cycle after the capture edge; no combinational path from in/enable to idx/valid.
REQ-014 BUSY: enable and in are ignored; a new vector is not captured until return to IDLE.
REQ-015 BUSY with valid==1 and ready==1 on an edge: clear bit idx in pending; if remaining pending !=0, idx <= lowest remaining set bit, valid stays 1.
REQ-016 Last handoff (remaining pending ==0): valid <= 0, state <= IDLE; idx holds last value.
REQ-017 BUSY with ready==0: idx, valid, pending held unchanged (stall indefinitely).
REQ-018 Emission order strictly ascending bit index; exactly popcount(captured in) handoffs per vector, one per accepted cycle max.
REQ-019 Back-to-back: capture allowed on the first edge after return to IDLE, so minimum gap between last handoff and next valid is one cycle.
REQ-020 Full vector (all ones) yields widthi handoffs; single-bit vector yields one handoff and returns to IDLE on it.

Reset
REQ-021 rst==0 asynchronously forces state IDLE, pending 0, idx 0, valid 0, busy 0, last 0 (if present), regardless of clk.
REQ-022 Reset mid-operation discards remaining pending bits; no index emitted after reset release until a new capture.
REQ-023 First capture possible on the first rising edge with rst==1.

Configuration
REQ-024 Macro ENC_8_SERIAL_LAST_EN defined: extra output last (1 bit, registered) high exactly when valid==1 and idx is the final pending bit of the vector.
REQ-025 Macro undefined: port last absent; all other behaviour identical.

Verification
REQ-026 Reset, enable=0, in=8'b0010_0100, ready=1 -> idx 2 then 5 on consecutive cycles, valid high 2 cycles, busy low after; last high with idx 5 when macro defined.
REQ-027 in=8'b1000_0001, ready held 0 for 4 cycles after capture -> idx 0, valid 1 held 4 cycles; ready=1 -> idx 7 next cycle, then valid 0.
REQ-028 During BUSY drive in=8'hFF, enable=0 -> ignored; only bits of first captured vector emitted.
REQ-029 in=8'hFF, ready=1 -> idx 0..7 over 8 cycles, return to IDLE; immediate new capture in=8'h10 -> idx 4 one cycle after IDLE.
REQ-030 in=8'h00 or enable=1 with in=8'h3C -> no capture, valid and busy stay 0.
REQ-031 Assert rst=0 mid-stream (after idx 1 of in=8'h0E) asynchronously -> valid, busy, idx 0 immediately; no further indices after release.
